// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch front end: two raw buttons are synchronised, debounced and edge-detected,
// then a 3-state run FSM drives the counter control code (0 CLEAR, 1 RUN, 2 HOLD).
module stopwatch_ctrl_fsm #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start,
   input  logic       btn_reset,
   output logic [1:0] control,
   output logic       running,
   output logic       ctrl_changed
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Bit 0 is the start/stop channel, bit 1 the clear channel.
   logic [1:0]            btn;
   logic [1:0]            s1_q, s2_q;
   logic [1:0]            db_q, db_d_q;
   logic [1:0][CNT_W-1:0] cnt_q;
   logic [1:0]            press;

   logic [1:0] state_q, state_d;
   logic [1:0] control_q;
   logic       running_q;
   logic       changed_q;

   assign btn   = {btn_reset, btn_start};
   assign press = db_q & ~db_d_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= '0;
         s2_q   <= '0;
         db_q   <= '0;
         db_d_q <= '0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= btn;
         s2_q   <= s1_q;
         db_d_q <= db_q;
         for (int i = 0; i < 2; i++) begin
            // Any disagreement-free cycle restarts the stability count.
            if (s2_q[i] == db_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_MAX) begin
               db_q[i]  <= s2_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (press[0]) state_d = S_RUN;
         S_RUN:   if (press[0]) state_d = S_PAUSE;
         S_PAUSE: if (press[0]) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
      // Clear has priority over a coincident start/stop press.
      if (press[1]) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         control_q <= 2'd0;
         running_q <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         control_q <= state_d;
         running_q <= (state_d == S_RUN);
         changed_q <= (state_d != control_q);
      end
   end

   assign control      = control_q;
   assign running      = running_q;
   assign ctrl_changed = changed_q;

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Scoreboard bench for stopwatch_ctrl_fsm: directed scenarios followed by random button
// activity, each cycle checked against a behavioural model of the debounced control.
module tb_stopwatch_ctrl_fsm;

   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_reset = 1'b0;
   logic [1:0] control;
   logic       running;
   logic       ctrl_changed;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   stopwatch_ctrl_fsm #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_start    (btn_start),
      .btn_reset    (btn_reset),
      .control      (control),
      .running      (running),
      .ctrl_changed (ctrl_changed)
   );

   always #5 clk = ~clk;

   // Expected {control, running, ctrl_changed} after each edge.
   logic [3:0] exp_q[$];

   // Reference model: each button seen through a two-sample delay; an accepted level flips
   // only after DC consecutive delayed samples disagree with it; presses are accepted rises.
   bit m_hist[2][$];
   bit m_lvl[2];
   bit m_lvl_prev[2];
   int m_streak[2];
   int m_ctrl;

   task automatic model_edge(input bit s, input bit r, input bit rs);
      bit raw[2];
      bit p_s, p_r;
      int nxt;
      bit v;
      raw[0] = s;
      raw[1] = r;
      if (rs) begin
         for (int b = 0; b < 2; b++) begin
            m_hist[b] = {1'b0, 1'b0};
            m_lvl[b] = 0;
            m_lvl_prev[b] = 0;
            m_streak[b] = 0;
         end
         m_ctrl = 0;
         exp_q.push_back(4'b0000);
         return;
      end
      p_s = m_lvl[0] && !m_lvl_prev[0];
      p_r = m_lvl[1] && !m_lvl_prev[1];
      if (p_r)      nxt = 0;
      else if (p_s) nxt = (m_ctrl == 1) ? 2 : 1;
      else          nxt = m_ctrl;
      exp_q.push_back({2'(nxt), (nxt == 1), (nxt != m_ctrl)});
      m_ctrl = nxt;
      for (int b = 0; b < 2; b++) begin
         v = m_hist[b].pop_front();
         m_hist[b].push_back(raw[b]);
         m_lvl_prev[b] = m_lvl[b];
         if (v != m_lvl[b]) begin
            m_streak[b]++;
            if (m_streak[b] == DC) begin
               m_lvl[b] = v;
               m_streak[b] = 0;
            end
         end else begin
            m_streak[b] = 0;
         end
      end
   endtask

   task automatic step(input bit s, input bit r, input bit rs);
      @(negedge clk);
      btn_start = s;
      btn_reset = r;
      rst = rs;
      @(posedge clk);
      cyc++;
      model_edge(s, r, rs);
   endtask

   task automatic hold(input bit s, input bit r, input int n);
      for (int i = 0; i < n; i++) step(s, r, 1'b0);
   endtask

   // Counts edges from the first sampled-high edge until control reaches want.
   task automatic latency_check(input string name, input bit s, input bit r,
                                input logic [1:0] want, input int want_lat);
      int lat;
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         step(s, r, 1'b0);
         #1;
         if (control == want) begin
            lat = i;
            break;
         end
      end
      total++;
      if (lat != want_lat) begin
         bad++;
         $display("FAIL %s: latency got %0d expected %0d", name, lat, want_lat);
      end
   endtask

   // Monitor: compares every output cycle against the queued expectation.
   initial begin
      logic [3:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if ({control, running, ctrl_changed} !== e) begin
               bad++;
               $display("FAIL cyc%0d: got ctrl=%0d run=%b chg=%b expected ctrl=%0d run=%b chg=%b",
                        cyc, control, running, ctrl_changed, e[3:2], e[1], e[0]);
            end
         end
      end
   end

   initial begin
      int n;
      bit s, r;
      // 1: reset
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
      hold(0, 0, 3);
      // 2: start held, exact latency, then release
      latency_check("start_lat", 1'b1, 1'b0, 2'd1, 7);
      hold(1, 0, 13);
      hold(0, 0, 10);
      // 3: short glitch rejected
      hold(1, 0, 3);
      hold(0, 0, 10);
      // 4: pause, resume, long hold gives one transition
      hold(1, 0, 10);
      hold(0, 0, 10);
      hold(1, 0, 100);
      hold(0, 0, 10);
      hold(1, 0, 10);
      hold(0, 0, 10);
      // 5: simultaneous start and clear from PAUSE go straight to CLEAR
      hold(1, 1, 12);
      hold(0, 0, 10);
      // clear while already idle: nothing changes
      hold(0, 1, 12);
      hold(0, 0, 10);
      // 6: reset mid-debounce, button still held afterwards
      hold(1, 0, 2);
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      latency_check("rst_lat", 1'b1, 1'b0, 2'd1, 7);
      hold(0, 0, 10);
      // random phase
      for (int k = 0; k < 300; k++) begin
         s = $urandom_range(0, 1);
         r = ($urandom_range(0, 5) == 0);
         n = $urandom_range(1, 10);
         if ($urandom_range(0, 40) == 0) step(s, r, 1'b1);
         hold(s, r, n);
      end
      hold(0, 0, 4);
      @(negedge clk);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
